// File: rtl/boruss_fetch_unit.sv
// boruss_fetch_unit: instruction fetch front end with a small prefetch FIFO.
// The PC walks the ROM one byte per cycle, and each {pc, data} pair is queued
// toward decode. A branch flushes the queue and redirects the PC. Halt stops
// new fetches, but decode can still drain whatever is already queued.
// Build option: define BORUSS_FETCH_PREFETCH_EN for a 4-entry queue. Without it
// the queue is a single holding register.
module boruss_fetch_unit #(
   parameter logic [7:0] RESET_PC = 8'h00
) (
   input  logic       clk,
   input  logic       reset,
   output logic [7:0] instruction_address,
   input  logic [7:0] instruction_data,
   input  logic       branch_valid,
   input  logic [7:0] branch_target,
   input  logic       halt,
   output logic       instr_valid,
   output logic [7:0] instr_data,
   output logic [7:0] instr_pc,
   input  logic       instr_ready,
   output logic       fetch_busy
);

`ifdef BORUSS_FETCH_PREFETCH_EN
   localparam int unsigned DEPTH = 4;
`else
   localparam int unsigned DEPTH = 1;
`endif
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   typedef logic [PTR_W-1:0] ptr_t;
   typedef logic [CNT_W-1:0] cnt_t;

   localparam cnt_t COUNT_FULL = cnt_t'(DEPTH);
   localparam ptr_t PTR_LAST   = ptr_t'(DEPTH - 1);

   typedef enum logic [1:0] {
      StFetch = 2'd0,
      StStall = 2'd1,
      StHalt  = 2'd2
   } state_e;

   state_e     state_q, state_d;
   logic [7:0] pc_q, pc_d;
   ptr_t       rd_ptr_q, rd_ptr_d;
   ptr_t       wr_ptr_q, wr_ptr_d;
   cnt_t       count_q, count_d;
   logic [7:0] fifo_pc_q   [DEPTH];
   logic [7:0] fifo_data_q [DEPTH];
   logic       push, pop;

   // Pointer wrap at DEPTH-1. This also covers non-power-of-two depths.
   function automatic ptr_t ptr_inc(input ptr_t p);
      return (p == PTR_LAST) ? '0 : ptr_t'(p + 1'b1);
   endfunction

   // Head visibility depends only on registered state, never on instr_ready.
   assign instr_valid         = (count_q != '0);
   assign instr_pc            = instr_valid ? fifo_pc_q[rd_ptr_q] : 8'h00;
   assign instr_data          = instr_valid ? fifo_data_q[rd_ptr_q] : 8'h00;
   assign instruction_address = pc_q;
   assign fetch_busy          = (state_q == StFetch);

   // Next-state decision, push/pop qualification and pointer/count update.
   always_comb begin
      pop      = instr_valid & instr_ready & ~branch_valid;
      state_d  = StFetch;
      pc_d     = pc_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;

      if (halt) begin
         state_d = StHalt;
      end else if ((count_q == COUNT_FULL) && !pop) begin
         state_d = StStall;
      end else begin
         state_d = StFetch;
      end

      push = (state_d == StFetch) & ~branch_valid;

      if (branch_valid) begin
         // Redirect wins over everything, including halt: drop the queue.
         pc_d     = branch_target;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
            pc_d     = pc_q + 8'd1;
         end
         if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // Control state: PC, pointers, count and FSM.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StFetch;
         pc_q     <= RESET_PC;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Queue storage. It has no reset because the outputs are masked by count.
   // When the queue is full and a pop happens, the write lands in the slot that
   // is being read out this cycle.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_pc_q[wr_ptr_q]   <= pc_q;
         fifo_data_q[wr_ptr_q] <= instruction_data;
      end
   end

endmodule

// File: doc/boruss_fetch_unit.md
BORUSS_FETCH_UNIT -- requirements
Module: boruss_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 8'h00: fetch address loaded on reset.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port instruction_address, output, 8: ROM fetch address, driven directly from the PC register.
REQ-005 SHALL have port instruction_data, input, 8: ROM data, combinationally valid in the same cycle as instruction_address.
REQ-006 SHALL have port branch_valid, input, 1: redirect request, single-cycle pulse.
REQ-007 SHALL have port branch_target, input, 8: redirect address, sampled when branch_valid=1.
REQ-008 SHALL have port halt, input, 1: level; while 1, no new fetches.
REQ-009 SHALL have port instr_valid, output, 1: FIFO head valid toward decode.
REQ-010 SHALL have port instr_data, output, 8: FIFO head instruction byte.
REQ-011 SHALL have port instr_pc, output, 8: address of the FIFO head instruction.
REQ-012 SHALL have port instr_ready, input, 1: decode accepts the head.
REQ-013 SHALL have port fetch_busy, output, 1: 1 when state is FETCH.

Function
REQ-014 SHALL hold a prefetch FIFO of DEPTH entries, each {pc[7:0], data[7:0]}, plus a count register 0..DEPTH.
REQ-015 SHALL implement a 2-bit FSM with states FETCH, STALL and HALT.
- FETCH: pushes each cycle.
- STALL: FIFO full, no pop.
- HALT: halt=1.
REQ-016 FSM transitions SHALL be evaluated each cycle with priority halt=1 -> HALT, else (count==DEPTH and no pop) -> STALL, else -> FETCH.
REQ-017 Push SHALL occur when the next-state decision is FETCH (not halted) and branch_valid=0: write {PC, instruction_data}, then PC <= PC+1.
REQ-018 PC increment SHALL wrap 8'hFF -> 8'h00 with no flag.
REQ-019 Pop SHALL occur when instr_valid=1 and instr_ready=1 and branch_valid=0; the head advances on the next edge.
REQ-020 Push and pop in the same cycle when full SHALL both complete, leaving count unchanged.
REQ-021 instr_valid SHALL equal (count != 0) and be registered-state-derived only, with no combinational path from instr_ready.
REQ-022 instr_data/instr_pc SHALL show the head entry whenever instr_valid=1, and SHALL be 8'h00 when the FIFO is empty.
REQ-023 Fetch-to-visible latency SHALL be 1 cycle: a byte pushed at edge N is on instr_data after edge N when the FIFO was empty.
REQ-024 branch_valid=1 SHALL take priority over push, pop and halt:
- flush the FIFO (count <= 0);
- load PC <= branch_target;
- no push or pop that cycle.
REQ-025 The first fetch after a branch SHALL use branch_target on the following cycle, provided halt=0.
REQ-026 While halt=1, a branch SHALL still update PC and flush, and pops SHALL continue to drain the FIFO.
REQ-027 Pointers SHALL wrap modulo DEPTH, and count SHALL never exceed DEPTH or underflow.

Reset
REQ-028 On reset=1 (asynchronous), the block SHALL set:
- PC <= RESET_PC, count <= 0, pointers <= 0;
- FSM <= FETCH;
- instr_valid=0, instr_data=8'h00, instr_pc=8'h00;
- instruction_address=RESET_PC, fetch_busy=1.
REQ-029 Reset asserted mid-operation SHALL discard all FIFO contents and any pending branch.
REQ-030 The first push after reset release SHALL occur on the first rising edge with reset=0.

Configuration
REQ-031 Macro BORUSS_FETCH_PREFETCH_EN defined SHALL set DEPTH=4 (2-bit pointers).
REQ-032 Macro BORUSS_FETCH_PREFETCH_EN undefined SHALL set DEPTH=1: a single holding register, so STALL is entered whenever the entry is not popped. All other REQs hold unchanged.

Verification
REQ-033 Reset release with RESET_PC=8'h10, instr_ready=1, ROM[a]=a^8'hA5 -> instr_pc 10,11,12 on consecutive cycles with instr_data B5,B4,B7; instr_valid=1 from cycle 1.
REQ-034 instr_ready=0 for 8 cycles (PREFETCH_EN) -> count reaches 4, FSM=STALL, fetch_busy=0, instruction_address frozen at 8'h14; instr_ready=1 -> entries 10..13 delivered in order, no gap.
REQ-035 Full FIFO holding 20..23, branch_valid=1 with branch_target=8'h80 -> next cycle instr_valid=0; following cycle instr_pc=8'h80.
REQ-036 PC=8'hFE, free-running -> instr_pc sequence FE, FF, 00, 01.
REQ-037 halt=1 with 3 entries queued, instr_ready=1 -> 3 entries drain, then instr_valid=0 and instruction_address constant; halt=0 resumes at the next PC.
REQ-038 reset pulse while 2 entries are queued -> instr_valid=0 immediately (asynchronous), instruction_address=RESET_PC.
